// File: rtl/hnoc_pkg.sv
// hnoc_pkg: helpers shared by the HNoC router blocks.
package hnoc_pkg;
    localparam int DropWidth = 16;

    function automatic logic in_range(input logic [31:0] d, input logic [31:0] lo, input logic [31:0] hi);
        return d >= lo && d <= hi;
    endfunction

    function automatic logic [DropWidth-1:0] sat_add(input logic [DropWidth-1:0] c, input int n);
        logic [DropWidth:0] s;
        s = {1'b0, c} + (DropWidth+1)'(n);
        return s[DropWidth] ? '1 : s[DropWidth-1:0];
    endfunction
endpackage

// File: rtl/hnoc_rr_arbiter.sv
// hnoc_rr_arbiter: round-robin arbiter, one-hot grant, pointer moves past the winner on a grant.
module hnoc_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);
    localparam int W = $clog2(N);

    logic [W-1:0] ptr, win;
    logic [W:0]   k;
    logic         hit;

    always_comb begin
        grant = '0;
        win   = ptr;
        hit   = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = (W+1)'(ptr) + (W+1)'(i);
            k = k >= (W+1)'(N) ? k - (W+1)'(N) : k;
            if (!hit && req[k[W-1:0]]) begin
                hit = 1'b1;
                win = k[W-1:0];
            end
        end
        if (hit) grant[win] = en;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (en && hit) ptr <= win == W'(N-1) ? '0 : win + W'(1);
    end
endmodule

// File: rtl/hnoc_xbar_router.sv
// hnoc_xbar_router: N-port crossbar with per-input FIFOs, address-range routing,
// per-output round-robin arbitration and saturating discard counter.
module hnoc_xbar_router
    import hnoc_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int NumPorts  = 4,
    parameter int AddrWidth = 8,
    parameter int FifoDepth = 4,
    parameter logic [NumPorts*AddrWidth-1:0] PortMin = {8'd3, 8'd2, 8'd1, 8'd0},
    parameter logic [NumPorts*AddrWidth-1:0] PortMax = {8'd3, 8'd2, 8'd1, 8'd0}
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NumPorts*DataWidth-1:0] i_data,
    input  logic [NumPorts-1:0]           i_data_valid,
    output logic [NumPorts-1:0]           o_data_ready,
    output logic [NumPorts*DataWidth-1:0] o_data,
    output logic [NumPorts-1:0]           o_data_valid,
    input  logic [NumPorts-1:0]           i_data_ready,
    output logic [DropWidth-1:0]          o_drop_count
);
    localparam int PtrW = $clog2(FifoDepth);

    logic [DataWidth-1:0] head [NumPorts];
    logic [NumPorts-1:0]  sel  [NumPorts];
    logic [NumPorts-1:0]  gnt  [NumPorts];
    logic [NumPorts-1:0]  drop;
    logic [DropWidth-1:0] drop_cnt;

    for (genvar p = 0; p < NumPorts; p++) begin : g_in
        logic [DataWidth-1:0] mem [FifoDepth];
        logic [PtrW-1:0]      wp, rp;
        logic [PtrW:0]        cnt, avail;
        logic                 push, push_q, pop, elig, granted;
        logic [AddrWidth-1:0] dst;
        logic [NumPorts-1:0]  hit;

        assign push            = i_data_valid[p] & o_data_ready[p];
        assign o_data_ready[p] = cnt != (PtrW+1)'(FifoDepth);
        assign elig            = avail != '0;
        assign head[p]         = mem[rp];
        assign dst             = head[p][DataWidth-1 -: AddrWidth];

        always_comb begin
            hit = '0;
            for (int o = 0; o < NumPorts; o++)
                hit[o] = in_range(32'(dst), 32'(PortMin[o*AddrWidth +: AddrWidth]),
                                  32'(PortMax[o*AddrWidth +: AddrWidth]));
        end

        always_comb begin
            granted = 1'b0;
            for (int o = 0; o < NumPorts; o++) granted = granted | gnt[o][p];
        end

        assign sel[p]  = elig ? hit & (~hit + NumPorts'(1)) : '0;
        assign drop[p] = elig & ~|hit;
        assign pop     = drop[p] | granted;

        // avail trails cnt by one cycle so a new flit is routed the cycle after it lands
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                wp     <= '0;
                rp     <= '0;
                cnt    <= '0;
                avail  <= '0;
                push_q <= 1'b0;
            end else begin
                if (push) begin
                    mem[wp] <= i_data[p*DataWidth +: DataWidth];
                    wp      <= wp + PtrW'(1);
                end
                if (pop) rp <= rp + PtrW'(1);
                cnt    <= cnt + (PtrW+1)'(push) - (PtrW+1)'(pop);
                avail  <= avail + (PtrW+1)'(push_q) - (PtrW+1)'(pop);
                push_q <= push;
            end
        end
    end

    for (genvar o = 0; o < NumPorts; o++) begin : g_out
        logic [NumPorts-1:0]  req;
        logic                 free, vld;
        logic [DataWidth-1:0] nxt, dat;

        assign free = ~vld | i_data_ready[o];

        always_comb begin
            req = '0;
            for (int i = 0; i < NumPorts; i++) req[i] = sel[i][o];
        end

        always_comb begin
            nxt = '0;
            for (int i = 0; i < NumPorts; i++) nxt = nxt | (gnt[o][i] ? head[i] : '0);
        end

        hnoc_rr_arbiter #(.N(NumPorts)) u_arb (
            .clk  (i_clk),
            .rst  (i_reset),
            .req  (req),
            .en   (free),
            .grant(gnt[o])
        );

        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                vld <= 1'b0;
                dat <= '0;
            end else if (free) begin
                vld <= |gnt[o];
                if (|gnt[o]) dat <= nxt;
            end
        end

        assign o_data_valid[o]                    = vld;
        assign o_data[o*DataWidth +: DataWidth]   = dat;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) drop_cnt <= '0;
        else drop_cnt <= sat_add(drop_cnt, $countones(drop));
    end

    assign o_drop_count = drop_cnt;
endmodule

// File: doc/hnoc_xbar_router.md
# hnoc_xbar_router

Parametrised single-clock crossbar router for the hierarchical NoC: NumPorts bidirectional valid/ready streaming ports, per-input FIFO buffering, address-range routing of single-flit packets, and per-output round-robin arbitration. Generalises the fixed pair of back-to-back 3-port switches at a tree centre into one N-port node with fair arbitration and unroutable-flit discard. Instantiated at every non-leaf position of the HNoC tree.

## Interface
- DataWidth, 32, flit width in bits
- NumPorts, 4, number of bidirectional ports (2..8)
- AddrWidth, 8, destination field width, taken from flit[DataWidth-1 -: AddrWidth]
- FifoDepth, 4, per-input FIFO entries (power of two, >=2)
- PortMin, {8'd3,8'd2,8'd1,8'd0}, packed NumPorts*AddrWidth vector, lowest destination routed to port p (slice p)
- PortMax, {8'd3,8'd2,8'd1,8'd0}, packed, highest destination routed to port p
- i_clk  input  1  clock
- i_reset  input  1  reset; one clock, synchronous, active-high
- i_data  input  NumPorts*DataWidth  ingress flits, slice p = port p
- i_data_valid  input  NumPorts  ingress valid
- o_data_ready  output  NumPorts  ingress ready (FIFO p not full)
- o_data  output  NumPorts*DataWidth  egress flits
- o_data_valid  output  NumPorts  egress valid
- i_data_ready  input  NumPorts  egress ready from downstream
- o_drop_count  output  16  saturating count of discarded unroutable flits

## Operation
- Ingress: flit accepted on port p when i_data_valid[p] & o_data_ready[p]; written to FIFO p.
- Route decode on FIFO head: destination d; target = lowest p with PortMin[p] <= d <= PortMax[p]. U-turn (target = own port) is legal.
- No matching range: head popped without output, o_drop_count += 1, saturating at 16'hFFFF. Drops from several inputs in one cycle each count (add popcount, saturate).
- Per output o: requesters = non-empty inputs whose head targets o. Output register o "free" when !o_data_valid[o] or i_data_ready[o]. When free and requesters exist, rr arbiter grants one; head popped, flit loaded into output register, o_data_valid[o] set.
- Round-robin: priority starts at (last granted + 1) mod NumPorts; pointer updates only on a grant. Reset pointer: input 0 highest priority.
- An input head requests exactly one output, so at most one pop per FIFO per cycle; different outputs served in parallel.
- Egress obeys valid/ready: once o_data_valid[o] high, o_data[o] stable until i_data_ready[o] sampled high.
- FIFO write and pop on the same cycle allowed when full (ready reflects current not-full state only; no combinational ready-through from pop).

## Timing
- Reset values: o_data_valid = 0, o_data = 0, o_data_ready = all 1 (FIFOs empty), o_drop_count = 0, rr pointers = 0. Reset mid-transfer discards all buffered and in-flight flits.
- Latency: flit accepted at edge N visible at FIFO head cycle N+1, o_data_valid at edge N+2 (2 cycles, uncontended, downstream ready).
- Throughput: one flit per output per cycle; one flit per input per cycle.
- Full: after FifoDepth accepts with no pop, o_data_ready[p] = 0 on next cycle.
- Drop counter updates the cycle after the unroutable flit reaches head.
- All outputs registered; no combinational path from i_data_valid or i_data_ready to any output.

## Structure
- Shared header hnoc_pkg: address-field extraction macro/function, range-match function, drop-counter width constant (16).
- Sub-module hnoc_rr_arbiter (NumPorts-wide request, one-hot grant, enable-gated pointer), one instance per output.
- FIFO: existing sync FIFO of the codebase if single-clock; else inline generate per input.
- Top: generate loops over inputs (FIFO + decode) and outputs (arbiter + output register).

## Test plan
- Single flit dest 8'd2 into port 0, all ready -> appears on o_data[2] exactly 2 cycles after accept, other outputs stay invalid.
- Ports 0,1,3 each send 4 flits to dest 8'd2 continuously -> output 2 carries grant order 0,1,3,0,1,3,... with no bubbles, 12 flits total.
- i_data_ready[1] held 0, 6 flits to dest 8'd1 from port 0 -> 4 in FIFO + 1 in output register, o_data_ready[0] falls after 5th accept; o_data[1] stable; release drains all 6 in order.
- Flits with dest 8'd9 from ports 0 and 2 same cycle -> o_drop_count goes 0 -> 2, no output valid; preload counter near 16'hFFFF -> saturates.
- Parallel: port 0->3 and port 3->0 simultaneously, each 8 flits -> both outputs full rate, 8 flits each, order preserved.
- Assert i_reset with flits buffered and outputs valid -> next cycle all o_data_valid 0, o_data_ready all 1, count 0; no stale flit emerges afterward.
